kbd_command_tx: RTL and testbench

KBD_COMMAND_TX -- requirements
Module: kbd_command_tx

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_sync.sv | 40 ++++
 rtl/kbd_command_tx.sv | 168 ++++++++++++++++
 tb/tb_kbd_command_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host definitions: transmit FSM states, command/response codes
package ps2_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_INHIBIT,
        TX_RTS,
        TX_SEND,
        TX_WAIT_ACK,
        TX_RELEASE
    } tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-flop synchronizers and falling-edge detectors for the PS/2 clock and data lines
module ps2_line_sync (
    input  logic clk_50,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall,
    output logic dat_fall
);

    logic clk_meta, clk_cur, clk_prev;
    logic dat_meta, dat_cur, dat_prev;

    // Idle bus is pulled high, so reset to 1 to avoid a false edge after reset
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            clk_meta <= 1'b1;
            clk_cur  <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_cur  <= 1'b1;
            dat_prev <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_cur  <= clk_meta;
            clk_prev <= clk_cur;
            dat_meta <= ps2_dat;
            dat_cur  <= dat_meta;
            dat_prev <= dat_cur;
        end
    end

    assign clk_sync = clk_cur;
    assign dat_sync = dat_cur;
    assign clk_fall = clk_prev & ~clk_cur;
    assign dat_fall = dat_prev & ~dat_cur;

endmodule

// File: rtl/kbd_command_tx.sv
// rtl/kbd_command_tx.sv - PS/2 host-to-device command transmitter (inhibit, request-to-send, frame, ACK)
module kbd_command_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       PS2_CLK_OE,
    output logic       PS2_DAT_OE
);

    import ps2_pkg::*;

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    tx_state_t   state, state_next;
    logic [19:0] cnt;
    logic        cnt_clear;
    logic [3:0]  edge_cnt;
    logic [7:0]  data_reg;
    logic        parity_reg;
    logic        dat_bit;
    logic        ack_seen;
    logic        done_set, error_set;
    logic        timeout_hit;

    logic clk_sync, dat_sync, clk_fall, dat_fall;
    logic unused_dat_fall;

    ps2_line_sync u_line_sync (
        .clk_50   (clk_50),
        .reset_n  (reset_n),
        .ps2_clk  (PS2_CLK),
        .ps2_dat  (PS2_DAT),
        .clk_sync (clk_sync),
        .dat_sync (dat_sync),
        .clk_fall (clk_fall),
        .dat_fall (dat_fall)
    );

    assign unused_dat_fall = dat_fall;

    // cnt is shared: inhibit length while in INHIBIT, transfer timeout from SEND onward
    assign timeout_hit = (cnt == TIMEOUT_LAST);

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        done_set   = 1'b0;
        error_set  = 1'b0;
        case (state)
            TX_IDLE: begin
                if (tx_valid) begin
                    state_next = TX_INHIBIT;
                    cnt_clear  = 1'b1;
                end
            end
            TX_INHIBIT: begin
                if (cnt == INHIBIT_LAST) state_next = TX_RTS;
            end
            TX_RTS: begin
                state_next = TX_SEND;
                cnt_clear  = 1'b1;
            end
            TX_SEND: begin
                if (timeout_hit) begin
                    state_next = TX_IDLE;
                    error_set  = 1'b1;
                end else if (clk_fall && edge_cnt == 4'd9) begin
                    state_next = TX_WAIT_ACK;
                end
            end
            TX_WAIT_ACK: begin
                if (timeout_hit) begin
                    state_next = TX_IDLE;
                    error_set  = 1'b1;
                end else if (clk_fall) begin
                    if (!dat_sync) begin
                        state_next = TX_RELEASE;
                    end else begin
                        state_next = TX_IDLE;
                        error_set  = 1'b1;
                    end
                end
            end
            TX_RELEASE: begin
                if (timeout_hit) begin
                    state_next = TX_IDLE;
                    error_set  = 1'b1;
                end else if (ack_seen && clk_sync && dat_sync) begin
                    state_next = TX_IDLE;
                    done_set   = 1'b1;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state      <= TX_IDLE;
            cnt        <= '0;
            edge_cnt   <= '0;
            data_reg   <= '0;
            parity_reg <= 1'b0;
            dat_bit    <= 1'b0;
            ack_seen   <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            state    <= state_next;
            tx_done  <= done_set;
            tx_error <= error_set;

            if (cnt_clear) begin
                cnt <= '0;
            end else if (state != TX_IDLE) begin
                cnt <= cnt + 20'd1;
            end

            case (state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        data_reg   <= tx_data;
                        parity_reg <= odd_parity(tx_data);
                        ack_seen   <= 1'b0;
                    end
                end
                TX_RTS: begin
                    edge_cnt <= '0;
                    dat_bit  <= 1'b1;
                end
                // Host changes data after each device falling edge: 8 data bits, parity, then stop
                TX_SEND: begin
                    if (clk_fall) begin
                        edge_cnt <= edge_cnt + 4'd1;
                        if (edge_cnt < 4'd8) begin
                            dat_bit <= ~data_reg[edge_cnt[2:0]];
                        end else if (edge_cnt == 4'd8) begin
                            dat_bit <= ~parity_reg;
                        end else begin
                            dat_bit <= 1'b0;
                        end
                    end
                end
                TX_WAIT_ACK: begin
                    if (clk_fall && !dat_sync) ack_seen <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign tx_ready   = (state == TX_IDLE);
    assign busy       = (state != TX_IDLE);
    assign PS2_CLK_OE = (state == TX_INHIBIT) || (state == TX_RTS);
    assign PS2_DAT_OE = (state == TX_RTS) || ((state == TX_SEND) && dat_bit);

endmodule

// File: tb/tb_kbd_command_tx.sv
// tb/tb_kbd_command_tx.sv - scoreboard bench for kbd_command_tx with an open-drain PS/2 device model
module tb_kbd_command_tx;

    localparam int INH  = 40;
    localparam int TO   = 3000;
    localparam int HALF = 20;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       is_done;
        logic       chk_frame;
    } exp_t;

    logic       clk_50 = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       PS2_CLK_OE, PS2_DAT_OE;
    logic       dev_clk, dev_dat;
    logic       ps2_clk_line, ps2_dat_line;

    logic [10:0] cap;
    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic        prev_done = 1'b0;
    logic        prev_err  = 1'b0;

    assign ps2_clk_line = dev_clk & ~PS2_CLK_OE;
    assign ps2_dat_line = dev_dat & ~PS2_DAT_OE;

    always #10 clk_50 = ~clk_50;

    kbd_command_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_50     (clk_50),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .busy       (busy),
        .PS2_CLK    (ps2_clk_line),
        .PS2_DAT    (ps2_dat_line),
        .PS2_CLK_OE (PS2_CLK_OE),
        .PS2_DAT_OE (PS2_DAT_OE)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done/error pulse consumes one expected result
    always @(negedge clk_50) begin
        exp_t e;
        if (tx_done || tx_error) begin
            check("pulse_exclusive", {31'd0, tx_done & tx_error}, 32'd0);
            check("pulse_width", {31'd0, (tx_done & prev_done) | (tx_error & prev_err)}, 32'd0);
            check("lines_released_on_pulse", {30'd0, PS2_CLK_OE, PS2_DAT_OE}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, tx_done, tx_error}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result_kind", {30'd0, tx_done, tx_error}, e.is_done ? 32'd2 : 32'd1);
                if (e.chk_frame)
                    check("frame_bits", {21'd0, cap}, {21'd0, 1'b1, e.par, e.data, 1'b0});
            end
        end
        prev_done = tx_done;
        prev_err  = tx_error;
    end

    task automatic wait_idle();
        int n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk_50);
            n++;
        end
        check("returns_idle", {31'd0, tx_ready}, 32'd1);
    endtask

    // Issues a command and checks the inhibit and request-to-send phases; returns in the first SEND cycle
    task automatic send_cmd(input logic [7:0] d, input bit hold);
        int n = 0;
        wait_idle();
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_50);
        if (hold) tx_data = 8'hEE;
        else tx_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        while (PS2_CLK_OE && !PS2_DAT_OE && n < INH + 10) begin
            n++;
            @(negedge clk_50);
        end
        check("inhibit_len", n, INH);
        check("rts_lines", {30'd0, PS2_CLK_OE, PS2_DAT_OE}, 32'd3);
        @(negedge clk_50);
        check("send_lines", {30'd0, PS2_CLK_OE, PS2_DAT_OE}, 32'd1);
    endtask

    // Device clocks 10 edges sampling DAT before each rise, then the ACK edge; abort_at leaves CLK low at that edge
    task automatic device_run(input bit ack, input int abort_at);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (HALF) @(negedge clk_50);
        cap[0] = ps2_dat_line;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            if (k == abort_at) return;
            repeat (HALF) @(negedge clk_50);
            cap[k[3:0]] = ps2_dat_line;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk_50);
        end
        tx_valid = 1'b0;
        dev_dat  = ack ? 1'b0 : 1'b1;
        repeat (5) @(negedge clk_50);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk_50);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk_50);
        dev_dat = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        cap      = '0;
        repeat (3) @(negedge clk_50);
        check("reset_outputs", {26'd0, tx_ready, busy, PS2_CLK_OE, PS2_DAT_OE, tx_done, tx_error}, 32'h20);
        reset_n = 1'b1;
        @(negedge clk_50);
        check("idle_outputs", {26'd0, tx_ready, busy, PS2_CLK_OE, PS2_DAT_OE, tx_done, tx_error}, 32'h20);

        // 0xED: bits 1,0,1,1,0,1,1,1 LSB first, parity 1
        exp_q.push_back('{8'hED, 1'b1, 1'b1, 1'b1});
        send_cmd(8'hED, 1'b0);
        device_run(1'b1, 0);
        wait_idle();

        // 0xF4: parity 0
        exp_q.push_back('{8'hF4, 1'b0, 1'b1, 1'b1});
        send_cmd(8'hF4, 1'b0);
        device_run(1'b1, 0);
        wait_idle();

        // Device leaves DAT high on the ACK edge
        exp_q.push_back('{8'hEE, 1'b1, 1'b0, 1'b1});
        send_cmd(8'hEE, 1'b0);
        device_run(1'b0, 0);
        wait_idle();

        // Device never clocks: error exactly TO cycles after RTS exit
        exp_q.push_back('{8'hED, 1'b1, 1'b0, 1'b0});
        send_cmd(8'hED, 1'b0);
        n = 0;
        while (!tx_error && n < TO + 50) begin
            @(negedge clk_50);
            n++;
        end
        check("timeout_cycles", n, TO);
        check("timeout_lines", {30'd0, PS2_CLK_OE, PS2_DAT_OE}, 32'd0);
        wait_idle();

        // One-cycle reset at edge 5 of a 0xFF transfer
        send_cmd(8'hFF, 1'b0);
        device_run(1'b1, 5);
        repeat (10) @(negedge clk_50);
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk_50);
        check("reset_mid_frame", {26'd0, tx_ready, busy, PS2_CLK_OE, PS2_DAT_OE, tx_done, tx_error}, 32'h20);
        reset_n = 1'b1;
        dev_clk = 1'b1;
        repeat (30) @(negedge clk_50);
        check("idle_after_reset", {31'd0, tx_ready}, 32'd1);

        exp_q.push_back('{8'hFF, 1'b1, 1'b1, 1'b1});
        send_cmd(8'hFF, 1'b0);
        device_run(1'b1, 0);
        wait_idle();

        // tx_valid held through the transfer with different data: ignored
        exp_q.push_back('{8'hED, 1'b1, 1'b1, 1'b1});
        send_cmd(8'hED, 1'b1);
        check("ready_low_in_send", {31'd0, tx_ready}, 32'd0);
        device_run(1'b1, 0);
        wait_idle();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_50);
            if (busy || PS2_CLK_OE) n++;
        end
        check("no_second_byte", n, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
